instruction_decoder: RTL



---
 rtl/instruction_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instruction_decoder.sv
//--------------------------------------------------------------------------
// Module : instruction_decoder
// Brief  : Instruction register plus registered field decoder with
//          illegal-opcode flagging and a gated immediate bus.
// Rev    : 1.0  initial release
//--------------------------------------------------------------------------
`default_nettype none

module instruction_decoder #(
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inst_wr,
    input  logic [INSTR_W-1:0]    instr_in,
    input  logic                  decoder_en,
    input  logic                  imm_en,
    output logic [3:0]            opcode,
    output logic [REG_ADDR_W-1:0] rD_sel,
    output logic [REG_ADDR_W-1:0] rA_sel,
    output logic [REG_ADDR_W-1:0] rB_sel,
    output logic [DATA_W-1:0]     imm_data,
    output logic [DATA_W-1:0]     imm_bus,
    output logic                  dec_valid,
    output logic                  illegal_op,
    output logic                  illegal_seen
);

    localparam logic [1:0] c_CLASS_R       = 2'b00;
    localparam logic [1:0] c_CLASS_I       = 2'b01;
    localparam logic [1:0] c_CLASS_ILLEGAL = 2'b10;
    localparam logic [3:0] c_OP_NOP        = 4'h0;

    logic [INSTR_W-1:0]    r_ir;
    logic [3:0]            r_opcode;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [REG_ADDR_W-1:0] r_ra;
    logic [REG_ADDR_W-1:0] r_rb;
    logic [DATA_W-1:0]     r_imm;
    logic                  r_dec_valid;
    logic                  r_illegal_op;
    logic                  r_illegal_seen;

    logic [3:0]            w_op_field;
    logic [2:0]            w_d_field;
    logic [2:0]            w_a_field;
    logic [2:0]            w_b_field;
    logic [7:0]            w_imm8;
    logic [DATA_W-1:0]     w_imm_sext;
    logic [1:0]            w_class;

    logic [3:0]            w_opcode_nxt;
    logic [REG_ADDR_W-1:0] w_rd_nxt;
    logic [REG_ADDR_W-1:0] w_ra_nxt;
    logic [REG_ADDR_W-1:0] w_rb_nxt;
    logic [DATA_W-1:0]     w_imm_nxt;
    logic                  w_illegal_nxt;

    // Field extraction always works on the held IR, so a simultaneous
    // inst_wr only becomes visible to the following decode.
    assign w_op_field = r_ir[15:12];
    assign w_d_field  = r_ir[11:9];
    assign w_a_field  = r_ir[8:6];
    assign w_b_field  = r_ir[5:3];
    assign w_imm8     = r_ir[7:0];
    assign w_imm_sext = {{(DATA_W-8){w_imm8[7]}}, w_imm8};

    always_comb begin
        w_class = c_CLASS_ILLEGAL;
        if (w_op_field[3] == 1'b0) begin
            w_class = c_CLASS_R;
        end else if (w_op_field[2] == 1'b0) begin
            w_class = c_CLASS_I;
        end
    end

    always_comb begin
        w_opcode_nxt  = c_OP_NOP;
        w_rd_nxt      = '0;
        w_ra_nxt      = '0;
        w_rb_nxt      = '0;
        w_imm_nxt     = '0;
        w_illegal_nxt = 1'b0;
        case (w_class)
            c_CLASS_R: begin
                w_opcode_nxt = w_op_field;
                w_rd_nxt     = REG_ADDR_W'(w_d_field);
                w_ra_nxt     = REG_ADDR_W'(w_a_field);
                w_rb_nxt     = REG_ADDR_W'(w_b_field);
            end
            c_CLASS_I: begin
                w_opcode_nxt = w_op_field;
                w_rd_nxt     = REG_ADDR_W'(w_d_field);
                w_imm_nxt    = w_imm_sext;
            end
            default: begin
                w_illegal_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir <= '0;
        end else if (inst_wr) begin
            r_ir <= instr_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_opcode       <= c_OP_NOP;
            r_rd           <= '0;
            r_ra           <= '0;
            r_rb           <= '0;
            r_imm          <= '0;
            r_dec_valid    <= 1'b0;
            r_illegal_op   <= 1'b0;
            r_illegal_seen <= 1'b0;
        end else begin
            // The illegal pulse lasts one cycle unless the next decode re-raises it.
            r_illegal_op <= 1'b0;
            if (decoder_en) begin
                r_opcode       <= w_opcode_nxt;
                r_rd           <= w_rd_nxt;
                r_ra           <= w_ra_nxt;
                r_rb           <= w_rb_nxt;
                r_imm          <= w_imm_nxt;
                r_dec_valid    <= 1'b1;
                r_illegal_op   <= w_illegal_nxt;
                r_illegal_seen <= r_illegal_seen | w_illegal_nxt;
            end
        end
    end

    assign opcode       = r_opcode;
    assign rD_sel       = r_rd;
    assign rA_sel       = r_ra;
    assign rB_sel       = r_rb;
    assign imm_data     = r_imm;
    assign dec_valid    = r_dec_valid;
    assign illegal_op   = r_illegal_op;
    assign illegal_seen = r_illegal_seen;
    assign imm_bus      = imm_en ? r_imm : '0;

endmodule

`default_nettype wire
